phase_seq_gen: RTL and testbench
================================

// Module: phase_seq_gen
// PURPOSE
//   Parametrised multi-phase timing generator for the multi-cycle RISC-V core.
//   One shared phase counter sweeps 0..PERIOD-1. Each of N_CH registered outputs
//   is high over its programmed phase window (fetch, alu, ctl_mul_div, ram, reg strobes).
//   Adds over the fixed-phase divider: any period and channel count, wrap-around
//   windows, synchronous restart, cycle markers, and an optional single-step mode.
// PARAMETERS
//   PERIOD   11                                   phases per instruction cycle (>=2)
//   N_CH     5                                    number of phase outputs (>=1)
//   CW       4                                    counter width; 2**CW > PERIOD required
//   RISE_POS {4'd10,4'd7,4'd5,4'd0,4'd4}          packed rise phases; ch i = [i*CW +: CW]
//   FALL_POS {4'd11,4'd8,4'd6,4'd1,4'd6}          packed fall phases; ch i = [i*CW +: CW]
// PORTS
//   clk_100M     in   1     system clock; all state updates on rising edge
//   rst          in   1     asynchronous, active-high reset
//   adv          in   1     1 = advance one phase this cycle; 0 = freeze all state (stall)
//   restart      in   1     synchronous; forces phase to 0 on the next edge
//   phase        out  CW    current phase, 0..PERIOD-1
//   ph_out       out  N_CH  per-channel phase strobes
//   cycle_start  out  1     high while phase==0
//   cycle_end    out  1     high while phase==PERIOD-1
// BEHAVIOUR
//   Reset
//     - On rst, immediately (asynchronously): phase=0; cycle_start=1; cycle_end=0.
//     - ph_out[i] = win_i(0) for every channel.
//     - Reset asserted mid-cycle abandons the cycle; no partial strobe survives it.
//   Window rule (R=rise, F=fall of channel i)
//     - R<F: high for R<=p<F.
//     - R>F: wraps; high for p>=R or p<F.
//     - R==F: always low.
//     - F==PERIOD means the window closes at the end of the cycle.
//   Registered outputs and latency
//     - All outputs are registered from next_phase, so ph_out/cycle_* are aligned
//       with phase: zero latency between phase and strobes.
//     - No combinational path from any input to any output.
//   Next-state priority
//     - restart → next_phase=0, regardless of adv.
//     - else adv=0 → hold phase and every output (strobes stay at current level).
//     - else p==PERIOD-1 → wrap to 0.
//     - else p+1.
//   Boundary conditions
//     - restart with adv=0 still resets to phase 0.
//     - restart at PERIOD-1 gives 0, same as a wrap.
//     - adv deasserted on the wrap edge holds at PERIOD-1.
//   Legality
//     - RISE_POS < PERIOD and FALL_POS <= PERIOD for every channel.
//     - 2**CW > PERIOD.
//     - Violations stop elaboration ($error in a generate check).
// CONFIGURATION
//   Macro PHASE_SEQ_STEP_EN (single-step debug)
//     - Defined: adds ports step_mode (in 1), step_req (in 1), halted (out 1, reset 0).
//     - step_mode=1: on wrapping to phase 0 the sequencer sets halted=1 and holds
//       (like adv=0) until a cycle with step_req=1 && adv=1.
//     - That cycle clears halted and advances to phase 1; one full cycle runs per request.
//     - step_req while not halted is ignored. restart clears halted.
//     - step_mode=0: halted=0 and behaviour is the normal run mode.
//   Not defined: ports absent; behaviour identical to step_mode=0.
// STRUCTURE
//   Package cpu_timing_pkg holds:
//     - default PERIOD/CW;
//     - channel index constants CH_ALU=0, CH_FETCH=1, CH_CTL=2, CH_RAM=3, CH_REG=4;
//     - function phase_in_win(p, r, f) implementing the window rule.
//   Sub-module phase_win_reg: one registered channel (inputs next_phase and hold;
//   parameters R, F); instantiated N_CH times in a generate loop.
// TESTING
//   1. Default params, rst then adv=1 for 22 cycles
//      -> phase 0..10,0..10; ch1 high only at p=0; ch0 at p=4,5; ch2 at p=5;
//         ch3 at p=7; ch4 at p=10.
//   2. adv=0 at phase 4 for 3 cycles
//      -> phase stays 4, ph_out stays 5'b00001; resumes at 5.
//   3. Override ch0 R=9, F=2 (wrap)
//      -> ch0 high at p=9,10,0,1 and low at p=2..8 across two periods.
//   4. restart at p=7 with adv=0
//      -> next cycle phase=0, cycle_start=1, ch1=1, ch3=0.
//   5. rst asserted at p=5 mid-clock
//      -> outputs take reset values before the next edge; phase=0 after release.
//   6. PHASE_SEQ_STEP_EN, step_mode=1
//      -> halts at p=0 with halted=1; one step_req pulse runs p=1..10,0 then halts again.

Source files
------------

// File: rtl/phase_seq_gen_pkg.sv
// Shared timing constants, channel indices and the phase-window rule for phase_seq_gen.
package cpu_timing_pkg;

    localparam int unsigned DEF_PERIOD = 32'd11;
    localparam int unsigned DEF_CW     = 32'd4;
    localparam int unsigned DEF_N_CH   = 32'd5;

    localparam logic [19:0] DEF_RISE_POS = {4'd10, 4'd7, 4'd5, 4'd0, 4'd4};
    localparam logic [19:0] DEF_FALL_POS = {4'd11, 4'd8, 4'd6, 4'd1, 4'd6};

    localparam int unsigned CH_ALU   = 32'd0;
    localparam int unsigned CH_FETCH = 32'd1;
    localparam int unsigned CH_CTL   = 32'd2;
    localparam int unsigned CH_RAM   = 32'd3;
    localparam int unsigned CH_REG   = 32'd4;

    // Window [r, f) on the phase circle; r > f wraps through phase 0, r == f is never high.
    function automatic logic phase_in_win(input int unsigned p,
                                          input int unsigned r,
                                          input int unsigned f);
        logic hit;
        if (r == f) begin
            hit = 1'b0;
        end else if (r < f) begin
            hit = (p >= r) && (p < f);
        end else begin
            hit = (p >= r) || (p < f);
        end
        return hit;
    endfunction

endpackage

// File: rtl/phase_seq_gen_if.sv
// Control/status bundle of phase_seq_gen; step-mode signals exist only with PHASE_SEQ_STEP_EN.
interface phase_seq_gen_if
    import cpu_timing_pkg::*;
#(
    parameter int unsigned CW   = DEF_CW,
    parameter int unsigned N_CH = DEF_N_CH
);
    logic            adv;
    logic            restart;
    logic [CW-1:0]   phase;
    logic [N_CH-1:0] ph_out;
    logic            cycle_start;
    logic            cycle_end;
`ifdef PHASE_SEQ_STEP_EN
    logic            step_mode;
    logic            step_req;
    logic            halted;

    modport master (output adv, restart, step_mode, step_req,
                    input  phase, ph_out, cycle_start, cycle_end, halted);
    modport slave  (input  adv, restart, step_mode, step_req,
                    output phase, ph_out, cycle_start, cycle_end, halted);
`else
    modport master (output adv, restart,
                    input  phase, ph_out, cycle_start, cycle_end);
    modport slave  (input  adv, restart,
                    output phase, ph_out, cycle_start, cycle_end);
`endif
endinterface

// File: rtl/phase_win_reg.sv
// One registered phase strobe: high while the upcoming phase lies inside window [R, F).
module phase_win_reg
    import cpu_timing_pkg::*;
#(
    parameter int unsigned CW = DEF_CW,
    parameter int unsigned R  = 32'd0,
    parameter int unsigned F  = 32'd1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] next_phase,
    input  logic          hold,
    output logic          q
);
    localparam logic RST_VAL = phase_in_win(32'd0, R, F);

    // Strobe register, computed from next_phase so it lines up with the phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (!hold) begin
            q <= phase_in_win(32'(next_phase), R, F);
        end
    end
endmodule

// File: rtl/phase_seq_gen.sv
// Multi-phase timing generator: shared phase counter plus N_CH registered window strobes.
// Optional single-step debug mode is compiled in with macro PHASE_SEQ_STEP_EN.
module phase_seq_gen
    import cpu_timing_pkg::*;
#(
    parameter int unsigned            PERIOD   = DEF_PERIOD,
    parameter int unsigned            N_CH     = DEF_N_CH,
    parameter int unsigned            CW       = DEF_CW,
    parameter logic [N_CH*CW-1:0]     RISE_POS = DEF_RISE_POS,
    parameter logic [N_CH*CW-1:0]     FALL_POS = DEF_FALL_POS
) (
    input logic           clk_100M,
    input logic           rst,
    phase_seq_gen_if.slave bus
);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 32'd1);

    logic [CW-1:0]   phase_r;
    logic [CW-1:0]   next_phase_s;
    logic            hold_s;
    logic            adv_eff_s;
    logic            cycle_start_r;
    logic            cycle_end_r;
    logic [N_CH-1:0] ph_s;

    if ((32'd1 << CW) <= PERIOD) begin : g_bad_cw
        $error("phase_seq_gen: 2**CW must exceed PERIOD");
    end
    if (PERIOD < 32'd2) begin : g_bad_period
        $error("phase_seq_gen: PERIOD must be at least 2");
    end
    if ($bits(bus.phase) != CW || $bits(bus.ph_out) != N_CH) begin : g_bad_if
        $error("phase_seq_gen: interface widths do not match CW/N_CH");
    end

`ifdef PHASE_SEQ_STEP_EN
    logic halted_r;
    logic halted_next_s;

    // Halt bookkeeping: set on a wrap in step mode, released by step_req together with adv.
    always_comb begin
        halted_next_s = halted_r;
        adv_eff_s     = bus.adv && (!(halted_r && bus.step_mode) || bus.step_req);
        if (bus.restart || !bus.step_mode) begin
            halted_next_s = 1'b0;
        end else if (halted_r) begin
            halted_next_s = !(bus.step_req && bus.adv);
        end else if (bus.adv && (phase_r == LAST)) begin
            halted_next_s = 1'b1;
        end else begin
            halted_next_s = 1'b0;
        end
    end

    // Halt flag register.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= halted_next_s;
        end
    end

    assign bus.halted = halted_r;
`else
    assign adv_eff_s = bus.adv;
`endif

    // Next-phase selection: restart beats stall, stall beats wrap/increment.
    always_comb begin
        next_phase_s = phase_r;
        hold_s       = 1'b1;
        if (bus.restart) begin
            next_phase_s = '0;
            hold_s       = 1'b0;
        end else if (!adv_eff_s) begin
            next_phase_s = phase_r;
            hold_s       = 1'b1;
        end else if (phase_r == LAST) begin
            next_phase_s = '0;
            hold_s       = 1'b0;
        end else begin
            next_phase_s = phase_r + CW'(1);
            hold_s       = 1'b0;
        end
    end

    // Phase counter and cycle markers, all taken from next_phase to stay aligned.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            phase_r       <= '0;
            cycle_start_r <= 1'b1;
            cycle_end_r   <= 1'b0;
        end else begin
            phase_r       <= next_phase_s;
            cycle_start_r <= (next_phase_s == '0);
            cycle_end_r   <= (next_phase_s == LAST);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam int unsigned R_I = 32'(RISE_POS[i*CW +: CW]);
        localparam int unsigned F_I = 32'(FALL_POS[i*CW +: CW]);

        if (R_I >= PERIOD || F_I > PERIOD) begin : g_bad_win
            $error("phase_seq_gen: channel window outside 0..PERIOD");
        end

        phase_win_reg #(
            .CW (CW),
            .R  (R_I),
            .F  (F_I)
        ) u_win (
            .clk        (clk_100M),
            .rst        (rst),
            .next_phase (next_phase_s),
            .hold       (hold_s),
            .q          (ph_s[i])
        );
    end

    assign bus.phase       = phase_r;
    assign bus.ph_out      = ph_s;
    assign bus.cycle_start = cycle_start_r;
    assign bus.cycle_end   = cycle_end_r;
endmodule

// File: tb/tb_phase_seq_gen.sv
// Self-checking bench for phase_seq_gen: vector table with a scoreboard queue, plus reset and step-mode sequences.
module tb_phase_seq_gen;
    import cpu_timing_pkg::*;

    localparam int unsigned CW     = 4;
    localparam int unsigned N      = 5;
    localparam int unsigned PERIOD = 11;

    typedef struct {
        logic          adv;
        logic          restart;
        logic          step_req;
        logic [CW-1:0] phase;
        logic [N-1:0]  ph;
        logic          cs;
        logic          ce;
        logic          b0;
        logic          halted;
    } vec_t;

    logic clk_100M = 1'b0;
    logic rst      = 1'b1;
    always #5 clk_100M = ~clk_100M;

    phase_seq_gen_if #(.CW(CW), .N_CH(N)) bus ();
    phase_seq_gen_if #(.CW(CW), .N_CH(N)) busb ();

    phase_seq_gen #(.PERIOD(PERIOD), .N_CH(N), .CW(CW)) dut (
        .clk_100M (clk_100M),
        .rst      (rst),
        .bus      (bus)
    );

    // Same timing as dut except channel 0 uses the wrapping window R=9, F=2.
    phase_seq_gen #(
        .PERIOD   (PERIOD),
        .N_CH     (N),
        .CW       (CW),
        .RISE_POS ({DEF_RISE_POS[19:4], 4'd9}),
        .FALL_POS ({DEF_FALL_POS[19:4], 4'd2})
    ) dut_b (
        .clk_100M (clk_100M),
        .rst      (rst),
        .bus      (busb)
    );

    assign busb.adv     = bus.adv;
    assign busb.restart = bus.restart;
`ifdef PHASE_SEQ_STEP_EN
    assign busb.step_mode = 1'b0;
    assign busb.step_req  = 1'b0;
`endif

    logic [N-1:0] exp_tab [PERIOD];
    vec_t vecs[$];
    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic a, input logic r, input logic s, input int p, input logic h);
        vec_t v;
        v.adv      = a;
        v.restart  = r;
        v.step_req = s;
        v.phase    = 4'(p);
        v.ph       = exp_tab[p];
        v.cs       = (p == 0);
        v.ce       = (p == 10);
        v.b0       = (p >= 9) || (p < 2);
        v.halted   = h;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk_100M);
        bus.adv     = v.adv;
        bus.restart = v.restart;
`ifdef PHASE_SEQ_STEP_EN
        bus.step_req = v.step_req;
`endif
        sb_q.push_back(v);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk_100M);
            n++;
        end
        #2;
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Scoreboard: each edge consumes the expectation pushed before it.
    initial begin
        forever begin
            vec_t e;
            @(posedge clk_100M);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("phase",       32'(bus.phase),       32'(e.phase));
                check("ph_out",      32'(bus.ph_out),      32'(e.ph));
                check("cycle_start", 32'(bus.cycle_start), 32'(e.cs));
                check("cycle_end",   32'(bus.cycle_end),   32'(e.ce));
                check("wrap_ch0",    32'(busb.ph_out[0]),  32'(e.b0));
                check("wrap_phase",  32'(busb.phase),      32'(e.phase));
`ifdef PHASE_SEQ_STEP_EN
                check("halted",      32'(bus.halted),      32'(e.halted));
`endif
            end
        end
    end

    initial begin
        for (int p = 0; p < PERIOD; p++) exp_tab[p] = '0;
        exp_tab[0][CH_FETCH] = 1'b1;
        exp_tab[4][CH_ALU]   = 1'b1;
        exp_tab[5][CH_ALU]   = 1'b1;
        exp_tab[5][CH_CTL]   = 1'b1;
        exp_tab[7][CH_RAM]   = 1'b1;
        exp_tab[10][CH_REG]  = 1'b1;

        bus.adv     = 1'b0;
        bus.restart = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
        bus.step_mode = 1'b0;
        bus.step_req  = 1'b0;
`endif

        // Two full periods of free running
        for (int i = 0; i < 22; i++) add_vec(1'b1, 1'b0, 1'b0, (i + 1) % 11, 1'b0);
        // Stall at phase 4 for three cycles, then resume
        for (int p = 1; p <= 4; p++) add_vec(1'b1, 1'b0, 1'b0, p, 1'b0);
        for (int i = 0; i < 3; i++) add_vec(1'b0, 1'b0, 1'b0, 4, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 5, 1'b0);
        // Restart at phase 7 while stalled
        add_vec(1'b1, 1'b0, 1'b0, 6, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 7, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 0, 1'b0);
        // Stall on the wrap edge, then restart at PERIOD-1 and at phase 0
        for (int p = 1; p <= 10; p++) add_vec(1'b1, 1'b0, 1'b0, p, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 10, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int p = 1; p <= 5; p++) add_vec(1'b1, 1'b0, 1'b0, p, 1'b0);

        repeat (2) @(negedge clk_100M);
        check("rst_phase",  32'(bus.phase),       32'd0);
        check("rst_ph_out", 32'(bus.ph_out),      32'(exp_tab[0]));
        check("rst_cs",     32'(bus.cycle_start), 32'd1);
        check("rst_ce",     32'(bus.cycle_end),   32'd0);
        check("rst_wrap0",  32'(busb.ph_out[0]),  32'd1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Asynchronous reset in the middle of phase 5
        @(posedge clk_100M);
        #3;
        check("pre_rst_phase", 32'(bus.phase), 32'd5);
        rst     = 1'b1;
        bus.adv = 1'b0;
        #1;
        check("mid_rst_phase",  32'(bus.phase),       32'd0);
        check("mid_rst_ph_out", 32'(bus.ph_out),      32'(exp_tab[0]));
        check("mid_rst_cs",     32'(bus.cycle_start), 32'd1);
        check("mid_rst_ce",     32'(bus.cycle_end),   32'd0);
        @(negedge clk_100M);
        rst = 1'b0;
        vecs.delete();
        add_vec(1'b0, 1'b0, 1'b0, 0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1, 1'b0);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
        drain();

`ifdef PHASE_SEQ_STEP_EN
        bus.step_mode = 1'b1;
        vecs.delete();
        add_vec(1'b1, 1'b1, 1'b0, 0, 1'b0);
        for (int p = 1; p <= 10; p++) add_vec(1'b1, 1'b0, 1'b0, p, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 0, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b1, 0, 1'b1);
        add_vec(1'b1, 1'b0, 1'b1, 1, 1'b0);
        add_vec(1'b1, 1'b0, 1'b1, 2, 1'b0);
        for (int p = 3; p <= 10; p++) add_vec(1'b1, 1'b0, 1'b0, p, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 0, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1, 1'b0);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
        drain();
        bus.step_mode = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
